// File: rtl/adder_result_checker.sv
// -----------------------------------------------------------------------------
// adder_result_checker
//
// Purpose:
//   Independently recomputes A + B + C one DIGIT_WIDTH-bit digit per clock and
//   compares the {carry, sum} it builds against the result reported by an
//   adder under test. Keeps pass/fail status, a completed-check counter, a
//   saturating mismatch counter, a sticky error flag, and a copy of the
//   expected value from the first mismatch seen since reset.
//   ADDER_WIDTH must be an integer multiple of DIGIT_WIDTH.
//   One check takes N + 2 cycles, where N = ADDER_WIDTH / DIGIT_WIDTH.
//
// Ports:
//   iClk          clock, all state changes on the rising edge
//   iRst          synchronous active-high reset, wins over a handshake
//   iValid        operands and adder result are presented
//   oReady        checker idle and able to accept (IDLE state)
//   iA, iB, iC    operands and carry-in given to the adder under test
//   iSum, iCarry  sum and carry-out reported by the adder under test
//   oDone         one-cycle pulse when a check completes
//   oPass         outcome of the last completed check (1 = match)
//   oErrSticky    set by any mismatch since reset
//   oCheckCnt     completed checks, wraps at 2^32
//   oErrCnt       mismatching checks, saturates at 16'hFFFF
//   oFirstErrExp  expected {carry, sum} of the first mismatch since reset
// -----------------------------------------------------------------------------
module adder_result_checker #(
    parameter int ADDER_WIDTH = 32,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iC,
    input  logic [ADDER_WIDTH-1:0] iSum,
    input  logic                   iCarry,
    output logic                   oDone,
    output logic                   oPass,
    output logic                   oErrSticky,
    output logic [31:0]            oCheckCnt,
    output logic [15:0]            oErrCnt,
    output logic [ADDER_WIDTH:0]   oFirstErrExp
);

    localparam int N     = ADDER_WIDTH / DIGIT_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;

    // Control state
    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_sticky;
    logic [31:0]            r_check_cnt;
    logic [15:0]            r_err_cnt;
    logic [ADDER_WIDTH:0]   r_first_exp;

    // Latched transaction and reference sum under construction
    logic [ADDER_WIDTH-1:0] r_a;
    logic [ADDER_WIDTH-1:0] r_b;
    logic [ADDER_WIDTH-1:0] r_dut_sum;
    logic                   r_dut_carry;
    logic [ADDER_WIDTH-1:0] r_ref;

    logic                   w_accept;
    logic [DIGIT_WIDTH-1:0] w_a_dig;
    logic [DIGIT_WIDTH-1:0] w_b_dig;
    logic [DIGIT_WIDTH:0]   w_dig_full;
    logic [ADDER_WIDTH:0]   w_expected;
    logic                   w_match;

    assign oReady   = (r_state == ST_IDLE);
    assign w_accept = iValid && oReady && !iRst;

    // Select digit k of each latched operand.
    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that
        // leaves a combinational output unassigned would infer a latch.
        w_a_dig = '0;
        w_b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_dig = r_a[k*DIGIT_WIDTH +: DIGIT_WIDTH];
                w_b_dig = r_b[k*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
    end

    assign w_dig_full = (DIGIT_WIDTH+1)'(w_a_dig) + (DIGIT_WIDTH+1)'(w_b_dig)
                      + (DIGIT_WIDTH+1)'(r_carry);
    assign w_expected = {r_carry, r_ref};
    assign w_match    = (w_expected == {r_dut_carry, r_dut_sum});

    // Control path: FSM, status and counters.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of the others, independent of order.
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_sticky    <= 1'b0;
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_first_exp <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= '0;
                        r_carry <= iC;
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_carry <= w_dig_full[DIGIT_WIDTH];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    r_pass      <= w_match;
                    r_done      <= 1'b1;
                    r_check_cnt <= r_check_cnt + 32'd1;
                    if (!w_match) begin
                        r_sticky <= 1'b1;
                        if (r_err_cnt != 16'hFFFF) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        // Only the first mismatch since reset is recorded.
                        if (!r_sticky) begin
                            r_first_exp <= w_expected;
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: operand capture and reference-sum digits.
    always_ff @(posedge iClk) begin
        // NOTE: these hold data only and need no reset; nothing reads them
        // before a handshake has loaded them.
        if (w_accept) begin
            r_a         <= iA;
            r_b         <= iB;
            r_dut_sum   <= iSum;
            r_dut_carry <= iCarry;
        end
        if (r_state == ST_COMPUTE) begin
            for (int k = 0; k < N; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_ref[k*DIGIT_WIDTH +: DIGIT_WIDTH] <= w_dig_full[DIGIT_WIDTH-1:0];
                end
            end
        end
    end

    assign oDone        = r_done;
    assign oPass        = r_pass;
    assign oErrSticky   = r_sticky;
    assign oCheckCnt    = r_check_cnt;
    assign oErrCnt      = r_err_cnt;
    assign oFirstErrExp = r_first_exp;

endmodule

// File: tb/tb_adder_result_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_result_checker
//
// Bench for adder_result_checker at default parameters (32-bit, 8-bit digits).
// A transaction-level model predicts every output from plain A + B + C
// arithmetic and a countdown of the check latency; a negedge compare process
// checks the DUT against it each cycle. Directed scenarios add hand-computed
// literal expectations, followed by a randomized run with sporadic resets.
// -----------------------------------------------------------------------------
module tb_adder_result_checker;

    localparam int W = 32;
    localparam int N = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iValid;
    logic          oReady;
    logic [W-1:0]  iA;
    logic [W-1:0]  iB;
    logic          iC;
    logic [W-1:0]  iSum;
    logic          iCarry;
    logic          oDone;
    logic          oPass;
    logic          oErrSticky;
    logic [31:0]   oCheckCnt;
    logic [15:0]   oErrCnt;
    logic [W:0]    oFirstErrExp;

    adder_result_checker #(.ADDER_WIDTH(W), .DIGIT_WIDTH(8)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iValid       (iValid),
        .oReady       (oReady),
        .iA           (iA),
        .iB           (iB),
        .iC           (iC),
        .iSum         (iSum),
        .iCarry       (iCarry),
        .oDone        (oDone),
        .oPass        (oPass),
        .oErrSticky   (oErrSticky),
        .oCheckCnt    (oCheckCnt),
        .oErrCnt      (oErrCnt),
        .oFirstErrExp (oFirstErrExp)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_busy    = 0;   // cycles until the checker is idle again
    logic        m_done    = 1'b0;
    logic        m_pass    = 1'b0;
    logic        m_sticky  = 1'b0;
    logic [31:0] m_check   = '0;
    logic [15:0] m_err     = '0;
    logic [W:0]  m_first   = '0;
    logic [W:0]  p_exp     = '0;
    logic [W:0]  p_got     = '0;
    logic        preload_req = 1'b0;
    logic        cmp_en    = 1'b0;
    logic        prev_done = 1'b0;

    always @(posedge iClk) begin
        if (iRst) begin
            m_busy = 0; m_done = 1'b0; m_pass = 1'b0; m_sticky = 1'b0;
            m_check = '0; m_err = '0; m_first = '0;
        end else begin
            m_done = 1'b0;
            if (preload_req) m_err = 16'hFFFE;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done  = 1'b1;
                    m_pass  = (p_got == p_exp);
                    m_check = m_check + 32'd1;
                    if (!m_pass) begin
                        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                        if (!m_sticky) m_first = p_exp;
                        m_sticky = 1'b1;
                    end
                end
            end else if (iValid) begin
                p_exp  = {1'b0, iA} + {1'b0, iB} + 33'(iC);
                p_got  = {iCarry, iSum};
                m_busy = N + 1;
            end
        end
    end

    always @(negedge iClk) begin
        if (cmp_en) begin
            check("ready",      oReady,       m_busy == 0);
            check("done",       oDone,        m_done);
            check("pass",       oPass,        m_pass);
            check("sticky",     oErrSticky,   m_sticky);
            check("check_cnt",  oCheckCnt,    m_check);
            check("err_cnt",    oErrCnt,      m_err);
            check("first_exp",  oFirstErrExp, m_first);
            check("done_twice", oDone && prev_done, 0);
        end
        prev_done = oDone;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b1; iValid = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    // Returns just after the handshake edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] s, input logic co);
        int guard = 0;
        @(negedge iClk);
        while (!oReady && guard < 100) begin
            @(negedge iClk);
            guard++;
        end
        check("send_ready", oReady, 1);
        iA = a; iB = b; iC = c; iSum = s; iCarry = co; iValid = 1'b1;
        @(posedge iClk);
        #1 iValid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        @(negedge iClk);
        while (!oDone && guard < 20) begin
            @(negedge iClk);
            guard++;
        end
        check("done_timeout", oDone, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [W-1:0] a, b, s;
        logic         c, co;
        logic [W:0]   tot;
        int           sel;

        iRst = 1'b1; iValid = 1'b0; iA = '0; iB = '0; iC = 1'b0; iSum = '0; iCarry = 1'b0;
        repeat (3) @(negedge iClk);

        // Reset state
        check("rst_ready",  oReady, 1);
        check("rst_done",   oDone, 0);
        check("rst_pass",   oPass, 0);
        check("rst_sticky", oErrSticky, 0);
        check("rst_cnt",    oCheckCnt, 0);
        check("rst_err",    oErrCnt, 0);
        check("rst_first",  oFirstErrExp, 0);
        iRst = 1'b0;
        cmp_en = 1'b1;

        // 1 + 2 + 0 = 3: done exactly in the 6th cycle after the handshake edge
        send(32'd1, 32'd2, 1'b0, 32'd3, 1'b0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge iClk);
            check("lat_done", oDone, cyc == 6);
        end
        check("simple_pass", oPass, 1);
        check("simple_cnt",  oCheckCnt, 1);
        check("simple_err",  oErrCnt, 0);

        // All-ones operands with carry-in: 33'h1FFFFFFFF
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        wait_done();
        check("ones_pass", oPass, 1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0);
        wait_done();
        check("ones_fail_pass",  oPass, 0);
        check("ones_fail_stick", oErrSticky, 1);
        check("ones_fail_err",   oErrCnt, 1);
        check("ones_fail_first", oFirstErrExp, 33'h1FFFFFFFF);
        check("ones_fail_cnt",   oCheckCnt, 3);

        // Two mismatches: first recorded expectation is kept
        do_reset();
        send(32'd1, 32'd2, 1'b0, 32'd4, 1'b0);
        wait_done();
        send(32'd8, 32'd8, 1'b0, 32'd0, 1'b0);
        wait_done();
        check("two_err_first", oFirstErrExp, 33'h000000003);
        check("two_err_cnt",   oErrCnt, 2);

        // Reset two cycles into a check aborts it
        send(32'd5, 32'd6, 1'b0, 32'd11, 1'b0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check("abort_ready",  oReady, 1);
        check("abort_done",   oDone, 0);
        check("abort_pass",   oPass, 0);
        check("abort_sticky", oErrSticky, 0);
        check("abort_cnt",    oCheckCnt, 0);
        check("abort_err",    oErrCnt, 0);
        check("abort_first",  oFirstErrExp, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge iClk);
            check("abort_no_done", oDone, 0);
        end
        send(32'd7, 32'd9, 1'b1, 32'd17, 1'b0);
        wait_done();
        check("after_abort_pass", oPass, 1);
        check("after_abort_cnt",  oCheckCnt, 1);

        // iValid held high for 30 edges: accepts at 0, 6, 12, 18, 24
        do_reset();
        @(negedge iClk);
        iValid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
            tot = {1'b0, a} + {1'b0, b} + 33'(c);
            iA = a; iB = b; iC = c; {iCarry, iSum} = tot;
            @(negedge iClk);
        end
        iValid = 1'b0;
        check("stream_done", oDone, 1);
        check("stream_cnt",  oCheckCnt, 5);
        check("stream_err",  oErrCnt, 0);

        // Randomized traffic with corrupted results and sporadic resets
        for (int i = 0; i < 900; i++) begin
            @(negedge iClk);
            iRst = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 32'hFFFFFFFF : (sel == 1) ? 32'd0 : 32'($urandom);
            b = (sel == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            c = 1'($urandom_range(0, 1));
            tot = {1'b0, a} + {1'b0, b} + 33'(c);
            if ($urandom_range(0, 2) == 0) tot = tot ^ (33'd1 << $urandom_range(0, 32));
            iA = a; iB = b; iC = c; {iCarry, s} = tot; iSum = s;
            iValid = ($urandom_range(0, 3) != 0);
        end
        @(negedge iClk);
        iRst = 1'b0; iValid = 1'b0;

        // Saturation of the mismatch counter from a preloaded 16'hFFFE
        do_reset();
        cmp_en = 1'b0;
        @(negedge iClk);
        force dut.r_err_cnt = 16'hFFFE;
        preload_req = 1'b1;
        @(posedge iClk);
        #1 preload_req = 1'b0;
        @(negedge iClk);
        release dut.r_err_cnt;
        @(posedge iClk);
        cmp_en = 1'b1;
        @(negedge iClk);
        check("sat_preload", oErrCnt, 16'hFFFE);
        send(32'd1, 32'd1, 1'b0, 32'd3, 1'b0);
        wait_done();
        check("sat_err_1", oErrCnt, 16'hFFFF);
        check("sat_cnt_1", oCheckCnt, 1);
        for (int i = 0; i < 2; i++) begin
            send(32'd2, 32'd2, 1'b0, 32'd5, 1'b0);
            wait_done();
        end
        check("sat_err_3", oErrCnt, 16'hFFFF);
        check("sat_cnt_3", oCheckCnt, 3);

        repeat (4) @(negedge iClk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 Parameter ADDER_WIDTH, default 32, operand/sum width in bits.
REQ-002 Parameter DIGIT_WIDTH, default 8, bits of reference sum computed per cycle; ADDER_WIDTH SHALL be an integer multiple of DIGIT_WIDTH; N = ADDER_WIDTH/DIGIT_WIDTH.
REQ-003 iClk  input  1  clock; all state on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iValid  input  1  operands plus adder result presented.
REQ-006 oReady  output  1  checker idle, can accept.
REQ-007 iA  input  ADDER_WIDTH  operand A.
REQ-008 iB  input  ADDER_WIDTH  operand B.
REQ-009 iC  input  1  carry-in.
REQ-010 iSum  input  ADDER_WIDTH  sum produced by adder under test.
REQ-011 iCarry  input  1  carry-out produced by adder under test.
REQ-012 oDone  output  1  one-cycle pulse, check complete.
REQ-013 oPass  output  1  result of last completed check, 1 = match.
REQ-014 oErrSticky  output  1  set on any mismatch since reset.
REQ-015 oCheckCnt  output  32  completed checks.
REQ-016 oErrCnt  output  16  mismatching checks, saturating.
REQ-017 oFirstErrExp  output  ADDER_WIDTH+1  expected {carry,sum} of first mismatch.

Function
REQ-018 FSM states IDLE, COMPUTE, COMPARE; oReady SHALL be 1 exactly when state is IDLE.
REQ-019 Handshake: iValid=1 and oReady=1 at a rising edge SHALL latch iA, iB, iC, iSum, iCarry, clear digit index to 0, load internal carry with iC, enter COMPUTE.
REQ-020 iValid while oReady=0 SHALL be ignored; latched values SHALL not change until the next accepted handshake.
REQ-021 Each COMPUTE cycle SHALL add digit k of A, B plus internal carry, store the DIGIT_WIDTH-bit result in digit k of the reference sum, update internal carry, increment k.
REQ-022 After N COMPUTE cycles (k = N-1 processed) FSM SHALL enter COMPARE for exactly one cycle.
REQ-023 At the edge leaving COMPARE: match = ({internal carry, reference sum} == {latched iCarry, latched iSum}); oPass <= match; oDone <= 1; oCheckCnt += 1 (wraps 2^32-1 -> 0); on mismatch oErrCnt += 1 unless 16'hFFFF, oErrSticky <= 1; FSM -> IDLE.
REQ-024 oFirstErrExp SHALL load the expected {carry,sum} only on a mismatch while oErrSticky=0; later mismatches SHALL not overwrite it.
REQ-025 oDone SHALL be 1 for exactly one cycle, the first IDLE cycle after COMPARE; a new handshake SHALL be accepted in that same cycle.
REQ-026 Latency: handshake at edge E -> oDone high in the cycle after edge E+N+1; throughput one check per N+2 cycles (6 for defaults).
REQ-027 Arithmetic SHALL be modulo 2^ADDER_WIDTH with carry-out as bit ADDER_WIDTH of A+B+C.
REQ-028 oPass SHALL hold its value until the next oDone.

Reset
REQ-029 iRst=1 SHALL force IDLE, oDone=0, oPass=0, oErrSticky=0, oCheckCnt=0, oErrCnt=0, oFirstErrExp=0, internal carry and index 0, in any state.
REQ-030 iRst asserted during COMPUTE or COMPARE SHALL abort the check with no oDone pulse and no counter update; iRst has priority over handshake.

Verification
REQ-031 A=1, B=2, C=0, Sum=3, Carry=0 -> oDone 6 cycles after handshake edge, oPass=1, oCheckCnt=1, oErrCnt=0.
REQ-032 A=B=32'hFFFFFFFF, C=1, Sum=32'hFFFFFFFF, Carry=1 -> oPass=1; same with Carry=0 -> oPass=0, oErrSticky=1, oErrCnt=1, oFirstErrExp=33'h1FFFFFFFF.
REQ-033 Two mismatches, first expected 33'h000000003, second 33'h000000010 -> oFirstErrExp stays 33'h000000003, oErrCnt=2.
REQ-034 iValid held high continuously with correct results -> accepts every 6 cycles, oReady low between, oCheckCnt counts 1,2,3..., oDone never two consecutive cycles.
REQ-035 iRst pulsed 2 cycles after handshake -> no oDone, all outputs at reset values, next handshake completes normally.
REQ-036 Force oErrCnt path with 65536 mismatches (or preloaded count via backdoor at 16'hFFFE) -> saturates at 16'hFFFF, oCheckCnt keeps incrementing.
